// File: rtl/interp_pkg.sv
// Shared constants for the interpolator output stage: widths, phase-select tags and FSM encodings.
package interp_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int LANES          = 16;
    localparam int IDX_W          = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_ORIG = 2'b00;
    localparam sel_t SEL_H    = 2'b10;
    localparam sel_t SEL_V    = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
endpackage

// File: rtl/interp_out_serializer_if.sv
// Block-in / pixel-out handshake bundle of the output serializer.
interface interp_out_serializer_if
    import interp_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF,
    parameter int LN = LANES
);
    logic                  in_valid;
    logic                  in_ready;
    sel_t                  in_sel;
    logic [LN*(DW+2)-1:0]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic [IDX_W-1:0]      out_idx;
    sel_t                  out_sel;
    logic                  out_last;

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_sel, out_last
    );

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_sel, out_last
    );
endinterface

// File: rtl/interp_clip.sv
// Saturating clip of a signed (DATA_WIDTH+2)-bit sample to the unsigned DATA_WIDTH-bit pixel range.
module interp_clip #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH+1:0] i_v,
    output logic        [DATA_WIDTH-1:0] o_pix,
    output logic                         o_sat
);
    // Sign bit set -> negative; otherwise bit DATA_WIDTH set -> above full scale.
    always_comb begin
        o_pix = i_v[DATA_WIDTH-1:0];
        o_sat = 1'b0;
        if (i_v[DATA_WIDTH+1]) begin
            o_pix = '0;
            o_sat = 1'b1;
        end else if (i_v[DATA_WIDTH]) begin
            o_pix = '1;
            o_sat = 1'b1;
        end
    end
endmodule

// File: rtl/interp_out_serializer.sv
// Captures a clipped 16-lane block and streams it one pixel per beat, tagged with its phase select.
//   state   | meaning
//   IDLE    | no block held, ready for input
//   SEND    | streaming buffer[r_idx]; reloads on last beat if input is waiting
module interp_out_serializer
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    interp_out_serializer_if.slave   bus,
    output logic                     sat_flag
);
    localparam int IW = DATA_WIDTH + 2;

    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_buf [LANES];
    logic [IDX_W-1:0]      r_idx;
    sel_t                  r_sel;
    logic                  r_sat;

    logic [DATA_WIDTH-1:0] w_pix [LANES];
    logic [LANES-1:0]      w_clip;
    logic                  w_send;
    logic                  w_last;
    logic                  w_ready;
    logic                  w_load;

    for (genvar k = 0; k < LANES; k++) begin : g_clip
        interp_clip #(.DATA_WIDTH(DATA_WIDTH)) u_clip (
            .i_v   (bus.in_data[k*IW +: IW]),
            .o_pix (w_pix[k]),
            .o_sat (w_clip[k])
        );
    end

    assign w_send  = (r_state == ST_SEND);
    assign w_last  = w_send && (r_idx == IDX_W'(LANES - 1));
    assign w_ready = !w_send || (w_last && bus.out_ready);
    assign w_load  = bus.in_valid && w_ready;

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_send;
    // Gate with valid so the output is a clean 0 while the unreset buffer is stale.
    assign bus.out_data  = w_send ? r_buf[r_idx] : '0;
    assign bus.out_idx   = r_idx;
    assign bus.out_sel   = r_sel;
    assign bus.out_last  = w_last;
    assign sat_flag      = r_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_sel   <= SEL_ORIG;
            r_sat   <= 1'b0;
        end else if (w_load) begin
            r_state <= ST_SEND;
            r_idx   <= '0;
            r_sel   <= bus.in_sel;
            r_sat   <= r_sat | (|w_clip);
        end else if (w_send && bus.out_ready) begin
            if (w_last) begin
                r_state <= ST_IDLE;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int k = 0; k < LANES; k++) begin
                r_buf[k] <= w_pix[k];
            end
        end
    end
endmodule

// File: tb/tb_interp_out_serializer.sv
// Directed scoreboard bench for interp_out_serializer: clipping, tagging, back-pressure, back-to-back and reset.
module tb_interp_out_serializer;
    import interp_pkg::*;

    localparam int DW = 8;
    localparam int IW = DW + 2;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] idx;
        logic [1:0] sel;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sat_flag;

    always #5 clk = ~clk;

    interp_out_serializer_if #(.DW(DW), .LN(LANES)) bus ();

    interp_out_serializer #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sat_flag (sat_flag)
    );

    beat_t       sb[$];
    int unsigned beat_cyc[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    beat_t       held;
    beat_t       exp_b;
    bit          have_hold = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clip_model(input int v);
        logic [31:0] t;
        t = v;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return t[7:0];
    endfunction

    // Output monitor: pops the scoreboard on every accepted beat, checks hold under back-pressure.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (have_hold) begin
                check("hold_data", 32'(bus.out_data), 32'(held.d));
                check("hold_idx",  32'(bus.out_idx),  32'(held.idx));
                check("hold_sel",  32'(bus.out_sel),  32'(held.sel));
            end
            if (bus.out_ready) begin
                beat_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat_data", 32'(bus.out_data), 32'(exp_b.d));
                    check("beat_idx",  32'(bus.out_idx),  32'(exp_b.idx));
                    check("beat_sel",  32'(bus.out_sel),  32'(exp_b.sel));
                    check("beat_last", 32'(bus.out_last), 32'(exp_b.last));
                end
                have_hold = 1'b0;
            end else begin
                held.d    = bus.out_data;
                held.idx  = bus.out_idx;
                held.sel  = bus.out_sel;
                held.last = bus.out_last;
                have_hold = 1'b1;
            end
        end else begin
            have_hold = 1'b0;
        end
    end

    task automatic send_block(input int lanes[16], input logic [1:0] sel, input bit keep);
        bit    ok;
        beat_t b;
        logic [31:0] t;
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            t = lanes[k];
            bus.in_data[k*IW +: IW] = t[IW-1:0];
        end
        bus.in_sel   = sel;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                for (int k = 0; k < 16; k++) begin
                    b.d    = clip_model(lanes[k]);
                    b.idx  = 4'(k);
                    b.sel  = sel;
                    b.last = (k == 15);
                    sb.push_back(b);
                end
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!keep) bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && (sb.size() != 0 || bus.out_valid); c++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    int lanes[16];
    int nb0;
    int last_i;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_idx",   32'(bus.out_idx),   32'd0);
        check("rst_out_sel",   32'(bus.out_sel),   32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_sat",       32'(sat_flag),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;

        // In-range block tagged SEL_H
        for (int k = 0; k < 16; k++) lanes[k] = k * 10;
        send_block(lanes, SEL_H, 1'b0);
        drain();
        check("inrange_sat", 32'(sat_flag), 32'd0);

        // Clip boundaries
        lanes[0] = -1; lanes[1] = -512; lanes[2] = 0; lanes[3] = 255;
        lanes[4] = 256; lanes[5] = 511; lanes[6] = 128;
        for (int k = 7; k < 16; k++) lanes[k] = k * 3;
        send_block(lanes, SEL_ORIG, 1'b0);
        check("clip_sat", 32'(sat_flag), 32'd1);
        drain();

        // Reset mid-block after 5 accepted beats
        for (int k = 0; k < 16; k++) lanes[k] = 200 - k;
        send_block(lanes, SEL_V, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("mid_idx_before_rst", 32'(bus.out_idx), 32'd5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sat",       32'(sat_flag),      32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        repeat (20) @(posedge clk);
        #1;

        // Back-pressure with out_ready pattern 1,0,0,1
        for (int k = 0; k < 16; k++) lanes[k] = 15 * k + 7;
        send_block(lanes, SEL_V, 1'b0);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        drain();

        // Back-to-back A (SEL_ORIG) then B (SEL_V)
        nb0 = beat_cyc.size();
        for (int k = 0; k < 16; k++) lanes[k] = k + 1;
        send_block(lanes, SEL_ORIG, 1'b1);
        for (int k = 0; k < 16; k++) lanes[k] = 300 - 20 * k;
        send_block(lanes, SEL_V, 1'b0);
        drain();
        check("b2b_beats", 32'(beat_cyc.size() - nb0), 32'd32);
        if (beat_cyc.size() >= nb0 + 32) begin
            last_i = beat_cyc.size() - 1;
            check("b2b_cycles", beat_cyc[last_i] - beat_cyc[last_i - 31], 32'd31);
        end else begin
            check("b2b_cycles_missing", 32'd0, 32'd1);
        end

        // Early input during A's beat 3 is ignored
        for (int k = 0; k < 16; k++) lanes[k] = 2 * k + 40;
        send_block(lanes, SEL_ORIG, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("early_idx", 32'(bus.out_idx), 32'd3);
        bus.in_valid = 1'b1;
        bus.in_sel   = SEL_V;
        bus.in_data  = {LANES{10'h3FF}};
        @(negedge clk);
        check("early_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) lanes[k] = 250 - 3 * k;
        send_block(lanes, SEL_H, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
